// File: rtl/uart_rx_bit_timer.sv
// Oversampling edge counter and frame bit counter for one UART RX frame.
// Emits early/mid/late sample strobes, bit_done and frame_done to the RX datapath.
module uart_rx_bit_timer #(
   parameter int PRESCALE_WD = 6,
   parameter int BIT_CNT_WD  = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [PRESCALE_WD-1:0] prescale,
   input  logic [BIT_CNT_WD-1:0]  frame_bits,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic [PRESCALE_WD-1:0] edge_count,
   output logic [BIT_CNT_WD-1:0]  bit_count,
   output logic                   sample_strb,
   output logic [1:0]             sample_idx,
   output logic                   bit_done,
   output logic                   frame_done,
   output logic                   cfg_err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state_reg, state_next;
   logic [PRESCALE_WD-1:0] edge_reg, edge_next;
   logic [BIT_CNT_WD-1:0]  bit_reg, bit_next;
   logic [PRESCALE_WD-1:0] p_reg, p_next;
   logic [BIT_CNT_WD-1:0]  n_reg, n_next;
   logic                   cfg_err_reg, cfg_err_next;

   logic                   cfg_legal;
   logic [PRESCALE_WD-1:0] p_last, s_mid, s_early, s_late;
   logic [BIT_CNT_WD-1:0]  n_last;
   logic                   last_edge, last_bit;

   assign cfg_legal = (prescale >= PRESCALE_WD'(4)) && (frame_bits != '0);

   // All decode thresholds come from the shadow copies, never the live inputs.
   assign p_last  = p_reg - PRESCALE_WD'(1);
   assign s_mid   = p_reg >> 1;
   assign s_early = s_mid - PRESCALE_WD'(1);
   assign s_late  = s_mid + PRESCALE_WD'(1);
   assign n_last  = n_reg - BIT_CNT_WD'(1);

   assign last_edge = (edge_reg == p_last);
   assign last_bit  = (bit_reg == n_last);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= IDLE;
         edge_reg    <= '0;
         bit_reg     <= '0;
         p_reg       <= '0;
         n_reg       <= '0;
         cfg_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         edge_reg    <= edge_next;
         bit_reg     <= bit_next;
         p_reg       <= p_next;
         n_reg       <= n_next;
         cfg_err_reg <= cfg_err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      edge_next    = edge_reg;
      bit_next     = bit_reg;
      p_next       = p_reg;
      n_next       = n_reg;
      cfg_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            // abort has priority over start while idle
            if (start && !abort) begin
               if (cfg_legal) begin
                  state_next = RUN;
                  edge_next  = '0;
                  bit_next   = '0;
                  p_next     = prescale;
                  n_next     = frame_bits;
               end else begin
                  cfg_err_next = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
               edge_next  = '0;
               bit_next   = '0;
            end else if (last_edge) begin
               edge_next = '0;
               if (last_bit) begin
                  state_next = IDLE;
                  bit_next   = '0;
               end else begin
                  bit_next = bit_reg + BIT_CNT_WD'(1);
               end
            end else begin
               edge_next = edge_reg + PRESCALE_WD'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sample_strb = 1'b0;
      sample_idx  = 2'd0;
      if (busy) begin
         if (edge_reg == s_early) begin
            sample_strb = 1'b1;
            sample_idx  = 2'd0;
         end else if (edge_reg == s_mid) begin
            sample_strb = 1'b1;
            sample_idx  = 2'd1;
         end else if (edge_reg == s_late) begin
            sample_strb = 1'b1;
            sample_idx  = 2'd2;
         end
      end
   end

   assign busy       = (state_reg == RUN);
   assign edge_count = edge_reg;
   assign bit_count  = bit_reg;
   assign bit_done   = busy && last_edge;
   assign frame_done = bit_done && last_bit;
   assign cfg_err    = cfg_err_reg;

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
- Parametrised successor to the UART RX edge/bit counter.
- Runs the oversampling edge counter and frame bit counter for one complete RX frame from a single start pulse.
- Frame length (start + data + parity + stop bits) and prescale are runtime-configurable and shadowed at frame start.
- Emits three mid-bit sample strobes for majority voting, plus bit_done and frame_done, to the RX FSM and data sampler.

Parameters:
PRESCALE_WD, 6, width of prescale and edge_count; max prescale 2^PRESCALE_WD-1
BIT_CNT_WD, 4, width of frame_bits and bit_count; max frame 2^BIT_CNT_WD-1 bits

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
prescale  input  PRESCALE_WD  oversampling ratio P (clocks per bit)
frame_bits  input  BIT_CNT_WD  total bits per frame N, including start/parity/stop
start  input  1  frame start request (level sampled each cycle)
abort  input  1  terminate current frame
busy  output  1  frame in progress
edge_count  output  PRESCALE_WD  position within current bit, 0..P-1
bit_count  output  BIT_CNT_WD  index of current bit, 0..N-1
sample_strb  output  1  high on each of 3 sample positions
sample_idx  output  2  0/1/2 = early/mid/late sample; 0 when sample_strb low
bit_done  output  1  last cycle of current bit
frame_done  output  1  last cycle of frame
cfg_err  output  1  one-cycle pulse: start rejected due to illegal config

Behaviour:
- Reset (RST=1, async): state IDLE; busy, edge_count, bit_count, cfg_err = 0; shadow P/N = 0. All decoded strobes are therefore 0.
- FSM has two states, IDLE and RUN.
- IDLE + start + legal config: next cycle RUN, busy=1, edge_count=0, bit_count=0.
  - Legal config is prescale >= 4 and frame_bits >= 1.
  - prescale and frame_bits are latched into shadow registers at this edge.
- IDLE + start + illegal config: remain IDLE; cfg_err=1 for exactly the next cycle.
- RUN, each cycle:
  - edge_count increments; at P-1 it wraps to 0 and bit_count increments.
  - At edge_count=P-1 and bit_count=N-1 the next state is IDLE with counts cleared to 0.
  - busy is high for exactly N*P cycles per frame.
- Shadowed config: changes to prescale/frame_bits while in RUN have no effect until the next start.
- start while in RUN: ignored; does not restart the frame and does not raise cfg_err.
- abort while in RUN: next cycle IDLE, counts 0; no frame_done or bit_done for the partial bit.
- abort and start together in IDLE: abort wins; stay IDLE, no cfg_err.
- Sample positions, with M = floor(P/2): samples at edge_count M-1 (idx 0), M (idx 1), M+1 (idx 2). P >= 4 guarantees all three lie in 1..P-1.
- Strobe decoding: sample_strb, sample_idx, bit_done and frame_done are combinational decodes of registered state/counts, qualified by busy. No added latency; high in the same cycle edge_count holds the matching value.
  - bit_done = busy & (edge_count == P-1).
  - frame_done = bit_done & (bit_count == N-1); bit_done and frame_done coincide on the final cycle.
- Arithmetic: all compares use shadow values; P-1 and M±1 are computed at PRESCALE_WD width. No overflow is possible under the legal-config rule.
- Back-to-back frames: start may be asserted in the cycle after frame_done (state IDLE). busy then drops for exactly one cycle.
- Reset mid-frame: immediate return to the reset values above; no strobes.

Test Plan:
- P=8, N=10, one start pulse -> busy high 80 cycles; sample_strb at edge_count 3,4,5 (idx 0,1,2) in every bit; 10 bit_done pulses; frame_done on cycle 80 alongside the 10th bit_done.
- P=4, N=1 -> busy 4 cycles; samples at edge 1,2,3; bit_done and frame_done both on cycle 4.
- P=3 (and separately N=0) with start in IDLE -> no busy; cfg_err high exactly 1 cycle.
- P=16, N=11; change prescale to 8 and frame_bits to 5 during bit 2; assert start during bit 4 -> frame still runs 176 cycles at P=16; samples at 7,8,9.
- P=8, N=10; abort at bit 3, edge 5 -> next cycle busy=0, counts 0, no frame_done. Separately assert RST at bit 6 -> outputs 0 immediately.
- Two frames, start held high continuously, P=8, N=2 -> busy 16 cycles, low 1 cycle, busy 16 cycles; 2 frame_done pulses.
